// File: rtl/gbn_receiver.sv
// gbn_receiver: go-back-n responder (SYN/SYN-ACK handshake, in-order delivery with cumulative ACKs, FIN teardown).
// Optional macro GBN_RX_STATS_EN adds saturating acc_count/dup_count statistics outputs.
module gbn_receiver #(
    parameter int DATA_W        = 8,
    parameter int RESEND_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [31:0]       ISN,
    input  logic              pkt_valid,
    input  logic [31:0]       SEQin,
    input  logic [31:0]       ACKin,
    input  logic [8:0]        flagsin,
    input  logic [DATA_W-1:0] datain,
    input  logic              packetsent,
    output logic              readyout,
    output logic [31:0]       SEQout,
    output logic [31:0]       ACKout,
    output logic [8:0]        flagsout,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
`ifdef GBN_RX_STATS_EN
    output logic [15:0]       acc_count,
    output logic [15:0]       dup_count,
`endif
    output logic [3:0]        statedisplay
);
    typedef enum logic [3:0] {
        S_LISTEN      = 4'd0,
        S_SYNACK      = 4'd1,
        S_SYNACK_WAIT = 4'd2,
        S_ESTAB       = 4'd3,
        S_ACK_SEND    = 4'd4,
        S_FINACK      = 4'd5,
        S_LAST_WAIT   = 4'd6
    } state_t;

    localparam int TW = $clog2(RESEND_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(RESEND_CYCLES);

    state_t        state;
    logic [31:0]   expected;
    logic          ack_pending;
    logic          fin_seen;
    logic [TW-1:0] timer;
    logic          proc;
    logic          in_order;
    logic          fin_hit;
    logic          accept;
    logic          discard;
    logic [31:0]   exp_nxt;
    logic          unused_flags;

    assign statedisplay = state;
    assign unused_flags = ^{flagsin[8:5], flagsin[3:2]};

    // Classify a packet arriving while connected (SYN packets are ignored there; nothing accepted after a remembered FIN)
    always_comb begin
        proc     = pkt_valid && !flagsin[1] && (state == S_ESTAB || (state == S_ACK_SEND && !fin_seen));
        in_order = SEQin == expected;
        fin_hit  = proc && in_order && flagsin[0];
        accept   = proc && in_order && !flagsin[0];
        discard  = proc && !in_order;
        exp_nxt  = expected + {31'b0, accept || fin_hit};
    end

    // Connection FSM with registered outputs; send fields are latched on the edge entering a send state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_LISTEN;
            expected    <= '0;
            ack_pending <= 1'b0;
            fin_seen    <= 1'b0;
            timer       <= '0;
            readyout    <= 1'b0;
            SEQout      <= '0;
            ACKout      <= '0;
            flagsout    <= '0;
            data_valid  <= 1'b0;
            data_out    <= '0;
            done        <= 1'b0;
`ifdef GBN_RX_STATS_EN
            acc_count   <= '0;
            dup_count   <= '0;
`endif
        end else begin
            readyout   <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            timer      <= (state == S_SYNACK_WAIT || state == S_LAST_WAIT) ? timer + 1'b1 : '0;
            if (!enable) begin
                if (state != S_LISTEN) begin
                    state       <= S_LISTEN;
                    ack_pending <= 1'b0;
                    fin_seen    <= 1'b0;
                    timer       <= '0;
`ifdef GBN_RX_STATS_EN
                    acc_count   <= '0;
                    dup_count   <= '0;
`endif
                end
            end else begin
                if (accept) begin
                    data_valid <= 1'b1;
                    data_out   <= datain;
                end
`ifdef GBN_RX_STATS_EN
                if (accept && acc_count != 16'hFFFF) acc_count <= acc_count + 16'd1;
                if (discard && dup_count != 16'hFFFF) dup_count <= dup_count + 16'd1;
`endif
                case (state)
                    S_LISTEN: if (pkt_valid && flagsin[1] && !flagsin[4]) begin
                        expected <= SEQin + 32'd1;
                        state    <= S_SYNACK;
                        readyout <= 1'b1;
                        flagsout <= 9'h012;
                        SEQout   <= ISN;
                        ACKout   <= SEQin + 32'd1;
                    end
                    S_SYNACK: if (packetsent) state <= S_SYNACK_WAIT;
                    S_SYNACK_WAIT: begin
                        if (pkt_valid && flagsin[4] && !flagsin[1] && ACKin == ISN + 32'd1) begin
                            state <= S_ESTAB;
                            timer <= '0;
                        end else if ((pkt_valid && flagsin[1]) || timer == TMAX) begin
                            state    <= S_SYNACK;
                            timer    <= '0;
                            readyout <= 1'b1;
                            flagsout <= 9'h012;
                            SEQout   <= ISN;
                            ACKout   <= expected;
                        end
                    end
                    S_ESTAB: begin
                        expected <= exp_nxt;
                        if (fin_hit || ack_pending) begin
                            state       <= fin_hit ? S_FINACK : S_ACK_SEND;
                            ack_pending <= 1'b0;
                            readyout    <= 1'b1;
                            flagsout    <= fin_hit ? 9'h011 : 9'h010;
                            SEQout      <= ISN + 32'd1;
                            ACKout      <= exp_nxt;
                        end else if (accept || discard) begin
                            ack_pending <= 1'b1;
                        end
                    end
                    S_ACK_SEND: begin
                        expected <= exp_nxt;
                        if (accept || discard) ack_pending <= 1'b1;
                        if (fin_hit) fin_seen <= 1'b1;
                        if (packetsent && (fin_seen || fin_hit)) begin
                            state       <= S_FINACK;
                            fin_seen    <= 1'b0;
                            ack_pending <= 1'b0;
                            readyout    <= 1'b1;
                            flagsout    <= 9'h011;
                            SEQout      <= ISN + 32'd1;
                            ACKout      <= exp_nxt;
                        end else if (packetsent) begin
                            state <= S_ESTAB;
                        end
                    end
                    S_FINACK: if (packetsent) state <= S_LAST_WAIT;
                    S_LAST_WAIT: begin
                        if (pkt_valid && flagsin[4] && ACKin == ISN + 32'd2) begin
                            state <= S_LISTEN;
                            timer <= '0;
                            done  <= 1'b1;
`ifdef GBN_RX_STATS_EN
                            acc_count <= '0;
                            dup_count <= '0;
`endif
                        end else if ((pkt_valid && flagsin[0] && SEQin == expected - 32'd1) || timer == TMAX) begin
                            state    <= S_FINACK;
                            timer    <= '0;
                            readyout <= 1'b1;
                            flagsout <= 9'h011;
                            SEQout   <= ISN + 32'd1;
                            ACKout   <= expected;
                        end
                    end
                    default: state <= S_LISTEN;
                endcase
            end
        end
    end
endmodule
